// File: rtl/window_io_controller.sv
`default_nettype none
// ============================================================================
// window_io_controller : SRAM read of one row segment per anchor, hand-off to
//                        the blur stage, and write-back of hysteresis results.
// Revision 1.0
// ============================================================================
module window_io_controller #(
    parameter int BLOCK_W  = 10,
    parameter int Y_OFFSET = 5,
    parameter int ADDR_W   = 32
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   en_filter,
    input  logic                   process_done,
    input  logic                   anchor_moving,
    input  logic [15:0]            anchor_x,
    input  logic [15:0]            anchor_y,
    input  logic [15:0]            width,
    input  logic [15:0]            height,
    input  logic [ADDR_W-1:0]      in_base,
    input  logic [ADDR_W-1:0]      out_base,
    input  logic [8*BLOCK_W-1:0]   result_in,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ready,
    output logic [8*BLOCK_W-1:0]   pixels_out,
    output logic                   window_valid,
    output logic                   io_final
);

    localparam int IDX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_W - 1);
    localparam logic [15:0]      Y_OFF16  = 16'(Y_OFFSET);

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [8*BLOCK_W-1:0]   shadow_q, shadow_d;
    logic [8*BLOCK_W-1:0]   pixels_q, pixels_d;
    logic                   window_valid_q, window_valid_d;

    logic [16:0]            col_x;
    logic                   col_ok;
    logic                   rd_ok;
    logic                   wr_ok;
    logic [15:0]            wr_row;
    logic [31:0]            rd_prod;
    logic [31:0]            wr_prod;
    logic [ADDR_W-1:0]      rd_addr;
    logic [ADDR_W-1:0]      wr_addr;
    logic [7:0]             wr_byte;
    logic [7:0]             rd_byte;
    logic                   step;

    // Column is kept 17 bits wide so anchor_x + i cannot wrap into range.
    assign col_x   = {1'b0, anchor_x} + {{(17-IDX_W){1'b0}}, idx_q};
    assign col_ok  = col_x < {1'b0, width};
    assign rd_ok   = col_ok && (anchor_y < height);
    assign wr_row  = anchor_y - Y_OFF16;
    assign wr_ok   = col_ok && (anchor_y >= Y_OFF16) && (wr_row < height);
    assign rd_prod = 32'(anchor_y) * 32'(width);
    assign wr_prod = 32'(wr_row) * 32'(width);
    assign rd_addr = in_base  + ADDR_W'(rd_prod) + ADDR_W'(col_x);
    assign wr_addr = out_base + ADDR_W'(wr_prod) + ADDR_W'(col_x);
    assign wr_byte = result_in[{idx_q, 3'b000} +: 8];
    assign rd_byte = rd_ok ? mem_rdata : 8'h00;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            shadow_q       <= '0;
            pixels_q       <= '0;
            window_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            pixels_q       <= pixels_d;
            window_valid_q <= window_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        pixels_d       = pixels_q;
        window_valid_d = 1'b0;
        step           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_filter) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end
            end

            S_READ: begin
                step = !rd_ok || mem_ready;
                if (step) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = rd_byte;
                    if (idx_q == LAST_IDX) begin
                        // Publish on the same edge that fills the last slot.
                        pixels_d       = shadow_d;
                        window_valid_d = 1'b1;
                        state_d        = S_WRITE;
                        idx_d          = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_WRITE: begin
                step = !wr_ok || mem_ready;
                if (step) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_WAIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_WAIT: begin
                if (process_done) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (anchor_moving) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 8'h00;
        io_final     = 1'b0;
        pixels_out   = pixels_q;
        window_valid = window_valid_q;

        case (state_q)
            S_READ: begin
                if (rd_ok) begin
                    mem_read = 1'b1;
                    mem_addr = rd_addr;
                end
            end
            S_WRITE: begin
                if (wr_ok) begin
                    mem_write = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_byte;
                end
            end
            S_WAIT: begin
                io_final = 1'b1;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_window_io_controller.sv
`default_nettype none
// ============================================================================
// tb_window_io_controller : randomized self-checking bench with an SRAM model
//                           and a transaction-level reference model.
// Revision 1.0
// ============================================================================
module tb_window_io_controller;

    localparam int BW = 10;
    localparam int YO = 5;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            en_filter = 1'b0;
    logic            process_done = 1'b0;
    logic            anchor_moving = 1'b0;
    logic [15:0]     anchor_x = '0;
    logic [15:0]     anchor_y = '0;
    logic [15:0]     width = '0;
    logic [15:0]     height = '0;
    logic [AW-1:0]   in_base = '0;
    logic [AW-1:0]   out_base = '0;
    logic [8*BW-1:0] result_in = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_read;
    logic            mem_write;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;
    logic            mem_ready;
    logic [8*BW-1:0] pixels_out;
    logic            window_valid;
    logic            io_final;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wait_cnt;
    logic [7:0] garbage;
    logic [7:0] sram_in [0:4095];

    window_io_controller #(
        .BLOCK_W  (BW),
        .Y_OFFSET (YO),
        .ADDR_W   (AW)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .en_filter     (en_filter),
        .process_done  (process_done),
        .anchor_moving (anchor_moving),
        .anchor_x      (anchor_x),
        .anchor_y      (anchor_y),
        .width         (width),
        .height        (height),
        .in_base       (in_base),
        .out_base      (out_base),
        .result_in     (result_in),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .pixels_out    (pixels_out),
        .window_valid  (window_valid),
        .io_final      (io_final)
    );

    always #5 clk = ~clk;

    // SRAM model: each access completes after lat wait cycles; data is junk until ready.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) wait_cnt <= 0;
        else if ((mem_read || mem_write) && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    always @(posedge clk) garbage <= 8'($urandom);
    assign mem_ready = (mem_read || mem_write) && (wait_cnt == lat);
    assign mem_rdata = mem_ready ? sram_in[mem_addr[11:0]] : garbage;

    task automatic randomize_result();
        for (int i = 0; i < BW; i++) result_in[8*i +: 8] = 8'($urandom);
    endtask

    // Runs one anchor from trigger to io_final; caller must be at a negedge.
    task automatic do_burst(input string name, input bit via_move);
        int unsigned exp_rd[$];
        int unsigned exp_wa[$];
        int unsigned exp_wd[$];
        int unsigned got_rd[$];
        int unsigned got_wa[$];
        int unsigned got_wd[$];
        logic [8*BW-1:0] exp_pix;
        logic [8*BW-1:0] got_pix;
        logic [8*BW-1:0] prev_pix;
        logic [AW-1:0]   prev_addr;
        logic [7:0]      prev_wd;
        int unsigned x, y, wy, a;
        int rd_cyc, wr_cyc, vcount, vcyc, fcyc, cyc;
        int proto_err, hold_err, stable_err;
        bit prev_pend, prev_rd, ok;

        exp_pix = '0; rd_cyc = 0; wr_cyc = 0;
        y = anchor_y;
        for (int i = 0; i < BW; i++) begin
            x = anchor_x + i;
            if (x < width && y < height) begin
                a = in_base + y * width + x;
                exp_rd.push_back(a);
                exp_pix[8*i +: 8] = sram_in[a[11:0]];
                rd_cyc += lat + 1;
            end else begin
                rd_cyc += 1;
            end
            if (y >= YO && (y - YO) < height && x < width) begin
                wy = y - YO;
                exp_wa.push_back(out_base + wy * width + x);
                exp_wd.push_back(int'(result_in[8*i +: 8]));
                wr_cyc += lat + 1;
            end else begin
                wr_cyc += 1;
            end
        end

        prev_pix = pixels_out;
        got_pix = '0;
        vcount = 0; vcyc = -1; fcyc = -1;
        proto_err = 0; hold_err = 0; stable_err = 0;
        prev_pend = 1'b0; prev_rd = 1'b0; prev_addr = '0; prev_wd = '0;
        if (via_move) anchor_moving = 1'b1;
        else en_filter = 1'b1;
        @(negedge clk);
        anchor_moving = 1'b0;
        en_filter = 1'b0;
        cyc = 1;
        while (cyc < 3000) begin
            if (mem_read && mem_write) proto_err++;
            if (prev_pend) begin
                if ((prev_rd ? !mem_read : !mem_write) || mem_addr !== prev_addr ||
                    (!prev_rd && mem_wdata !== prev_wd)) hold_err++;
            end
            prev_pend = (mem_read || mem_write) && !mem_ready;
            prev_rd = mem_read;
            prev_addr = mem_addr;
            prev_wd = mem_wdata;
            if (mem_read && mem_ready) got_rd.push_back(mem_addr);
            if (mem_write && mem_ready) begin
                got_wa.push_back(mem_addr);
                got_wd.push_back(int'(mem_wdata));
            end
            if (window_valid) begin
                vcount++;
                vcyc = cyc;
                got_pix = pixels_out;
            end else if (pixels_out !== prev_pix) begin
                stable_err++;
            end
            prev_pix = pixels_out;
            if (io_final) begin
                fcyc = cyc;
                break;
            end
            cyc++;
            @(negedge clk);
        end

        checks++;
        if (fcyc < 0) begin
            errors++;
            $display("FAIL %s timeout: io_final not seen within %0d cycles", name, cyc);
        end
        checks++;
        if (vcount != 1) begin
            errors++;
            $display("FAIL %s valid_pulses: got %0d, expected 1", name, vcount);
        end
        checks++;
        if (vcyc != 1 + rd_cyc) begin
            errors++;
            $display("FAIL %s valid_cycle: got %0d, expected %0d", name, vcyc, 1 + rd_cyc);
        end
        checks++;
        if (fcyc != 1 + rd_cyc + wr_cyc) begin
            errors++;
            $display("FAIL %s final_cycle: got %0d, expected %0d", name, fcyc, 1 + rd_cyc + wr_cyc);
        end
        checks++;
        if (got_pix !== exp_pix) begin
            errors++;
            $display("FAIL %s pixels: got %h, expected %h", name, got_pix, exp_pix);
        end
        ok = (got_rd.size() == exp_rd.size());
        if (ok) foreach (exp_rd[k]) if (got_rd[k] != exp_rd[k]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s read_addrs: got %0d reads (first %h), expected %0d (first %h)", name,
                     got_rd.size(), (got_rd.size() > 0) ? got_rd[0] : 0,
                     exp_rd.size(), (exp_rd.size() > 0) ? exp_rd[0] : 0);
        end
        ok = (got_wa.size() == exp_wa.size());
        if (ok) foreach (exp_wa[k]) if (got_wa[k] != exp_wa[k] || got_wd[k] != exp_wd[k]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s writes: got %0d writes (first %h/%h), expected %0d (first %h/%h)", name,
                     got_wa.size(), (got_wa.size() > 0) ? got_wa[0] : 0, (got_wd.size() > 0) ? got_wd[0] : 0,
                     exp_wa.size(), (exp_wa.size() > 0) ? exp_wa[0] : 0, (exp_wd.size() > 0) ? exp_wd[0] : 0);
        end
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL %s rd_wr_overlap: got %0d cycles, expected 0", name, proto_err);
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL %s request_hold: got %0d violations, expected 0", name, hold_err);
        end
        checks++;
        if (stable_err != 0) begin
            errors++;
            $display("FAIL %s pixels_stable: got %0d changes outside valid, expected 0", name, stable_err);
        end
    endtask

    task automatic test_reset();
        int act;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_read, mem_write, window_valid, io_final} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 0000", {mem_read, mem_write, window_valid, io_final});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: got addr %h wdata %h, expected 0", mem_addr, mem_wdata);
        end
        checks++;
        if (pixels_out !== '0) begin
            errors++;
            $display("FAIL reset_pixels: got %h, expected 0", pixels_out);
        end
        n_rst = 1'b1;
        act = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_read || mem_write || window_valid || io_final) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d active cycles, expected 0", act);
        end
    endtask

    task automatic test_basic();
        anchor_x = 0; anchor_y = 0; width = 20; height = 8;
        in_base = 32'h0; out_base = 32'h1000; lat = 0;
        randomize_result();
        do_burst("basic", 1'b0);
    endtask

    task automatic test_edge_x();
        anchor_x = 15; anchor_y = 2; width = 20; height = 8; lat = 0;
        do_burst("edge_x", 1'b1);
    endtask

    task automatic test_write_back();
        anchor_x = 0; anchor_y = 6; width = 20; height = 8; lat = 0;
        randomize_result();
        do_burst("write_back", 1'b1);
    endtask

    task automatic test_latency();
        anchor_x = 3; anchor_y = 7; width = 20; height = 8; lat = 3;
        randomize_result();
        do_burst("latency", 1'b1);
    endtask

    task automatic test_both_high();
        int act;
        anchor_x = 0; anchor_y = 1; lat = 0;
        anchor_moving = 1'b1;
        process_done = 1'b1;
        @(negedge clk);
        anchor_moving = 1'b0;
        process_done = 1'b0;
        checks++;
        if (io_final !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL both_high: got io_final %b mem_read %b, expected 0 0", io_final, mem_read);
        end
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_read || mem_write || window_valid || io_final) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL both_idle: got %0d active cycles, expected 0", act);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            width    = 16'($urandom_range(8, 40));
            height   = 16'($urandom_range(2, 12));
            anchor_x = 16'($urandom_range(0, int'(width) + 2));
            anchor_y = 16'($urandom_range(0, int'(height) + 6));
            in_base  = AW'($urandom_range(0, 1023));
            out_base = AW'(32'h1000 + $urandom_range(0, 1023));
            lat      = $urandom_range(0, 2);
            randomize_result();
            do_burst("random", n != 0);
        end
    endtask

    task automatic test_reset_mid();
        int act;
        anchor_x = 0; anchor_y = 0; width = 20; height = 8;
        in_base = 32'h0; out_base = 32'h1000; lat = 3;
        anchor_moving = 1'b1;
        @(negedge clk);
        anchor_moving = 1'b0;
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_read: got mem_read %b, expected 1", mem_read);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, io_final, window_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %b, expected 0000", {mem_read, mem_write, io_final, window_valid});
        end
        checks++;
        if (pixels_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_pixels: got %h, expected 0", pixels_out);
        end
        @(negedge clk);
        n_rst = 1'b1;
        act = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_read || mem_write || window_valid || io_final) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL mid_reset_idle: got %0d active cycles, expected 0", act);
        end
        lat = 1;
        randomize_result();
        anchor_y = 5;
        do_burst("after_reset", 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) sram_in[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_edge_x();
        test_write_back();
        test_latency();
        test_both_high();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
